adv_cmd_encoder: RTL and testbench

Player-side command encoder for the room adventure game. It turns four raw, bouncing direction pushbuttons into clean single-cycle `n`/`s`/`e`/`w` move pulses for the room state machine. At most one move is issued per physical press. All moves are suppressed once the game reports a win or a death. It sits between the board buttons and the room FSM's direction inputs, in the same clock domain as the FSM.

---
 rtl/adv_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 57 +++++
 rtl/adv_cmd_encoder.sv | 107 ++++++++++
 tb/tb_adv_cmd_encoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/adv_pkg.sv
// Shared types for the room adventure game: arbiter FSM states and move directions.
package adv_pkg;

   // Command arbiter states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PULSE   = 2'd1,
      HOLDOFF = 2'd2,
      LOCKED  = 2'd3
   } adv_state_e;

   // Direction index, also used by the room FSM
   typedef enum logic [1:0] {
      DIR_N = 2'd0,
      DIR_S = 2'd1,
      DIR_E = 2'd2,
      DIR_W = 2'd3
   } adv_dir_e;

   localparam int unsigned NUM_DIRS = 4;

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchronizer, level debounce counter and rising-edge press detect.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic stable,
   output logic press
);

   localparam logic [7:0] LP_DB = DEBOUNCE_CYCLES[7:0];

   logic       r_sync1;
   logic       r_sync2;
   logic       r_stable;
   logic       r_press;
   logic [7:0] r_cnt;
   logic       w_accept;

   // The count reaches the threshold on this edge, so the new level is taken
   assign w_accept = (r_sync2 != r_stable) && ((r_cnt + 8'd1) == LP_DB);

   // Synchronize the asynchronous button level into the clock domain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= raw;
         r_sync2 <= r_sync1;
      end
   end

   // Count cycles of disagreement; accept the new level once it has held long enough
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt    <= 8'd0;
         r_stable <= 1'b0;
         r_press  <= 1'b0;
      end else begin
         r_press <= w_accept && r_sync2;
         if (r_sync2 == r_stable) begin
            r_cnt <= 8'd0;
         end else if (w_accept) begin
            r_cnt    <= 8'd0;
            r_stable <= r_sync2;
         end else begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   assign stable = r_stable;
   assign press  = r_press;

endmodule

// File: rtl/adv_cmd_encoder.sv
// Turns four bouncing direction buttons into one-cycle n/s/e/w move pulses, one per press,
// suppressed for good once the game is won or the player is dead.
module adv_cmd_encoder
   import adv_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_n,
   input  logic       btn_s,
   input  logic       btn_e,
   input  logic       btn_w,
   input  logic       win,
   input  logic       d,
   output logic       n,
   output logic       s,
   output logic       e,
   output logic       w,
   output logic       busy,
   output logic       locked,
   output logic [7:0] cmd_count
);

   logic [NUM_DIRS-1:0] w_raw;
   logic [NUM_DIRS-1:0] w_stable;
   logic [NUM_DIRS-1:0] w_press;

   adv_state_e r_state;
   adv_state_e w_state_nxt;
   adv_dir_e   r_dir;
   adv_dir_e   w_dir_nxt;
   logic [7:0] r_cmd_count;

   assign w_raw = {btn_w, btn_e, btn_s, btn_n};

   for (genvar gi = 0; gi < NUM_DIRS; gi++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn_debounce (
         .clk    (clk),
         .reset_n(reset_n),
         .raw    (w_raw[gi]),
         .stable (w_stable[gi]),
         .press  (w_press[gi])
      );
   end

   // Arbiter next state: priority encode presses in IDLE, lockout overrides everything
   always_comb begin
      w_state_nxt = r_state;
      w_dir_nxt   = r_dir;
      unique case (r_state)
         IDLE: begin
            if (w_press[DIR_N]) begin
               w_state_nxt = PULSE;
               w_dir_nxt   = DIR_N;
            end else if (w_press[DIR_S]) begin
               w_state_nxt = PULSE;
               w_dir_nxt   = DIR_S;
            end else if (w_press[DIR_E]) begin
               w_state_nxt = PULSE;
               w_dir_nxt   = DIR_E;
            end else if (w_press[DIR_W]) begin
               w_state_nxt = PULSE;
               w_dir_nxt   = DIR_W;
            end
         end
         PULSE:   w_state_nxt = HOLDOFF;
         HOLDOFF: if (w_stable == '0) w_state_nxt = IDLE;
         LOCKED:  w_state_nxt = LOCKED;
         default: w_state_nxt = IDLE;
      endcase
      if (win | d) begin
         w_state_nxt = LOCKED;
      end
   end

   // Arbiter state and latched direction
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_dir   <= DIR_N;
      end else begin
         r_state <= w_state_nxt;
         r_dir   <= w_dir_nxt;
      end
   end

   // Count every pulse that was shown, including one cut short by a lockout
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cmd_count <= 8'd0;
      end else if (r_state == PULSE) begin
         r_cmd_count <= r_cmd_count + 8'd1;
      end
   end

   assign n         = (r_state == PULSE) && (r_dir == DIR_N);
   assign s         = (r_state == PULSE) && (r_dir == DIR_S);
   assign e         = (r_state == PULSE) && (r_dir == DIR_E);
   assign w         = (r_state == PULSE) && (r_dir == DIR_W);
   assign busy      = (r_state == PULSE) || (r_state == HOLDOFF);
   assign locked    = (r_state == LOCKED);
   assign cmd_count = r_cmd_count;

endmodule

// File: tb/tb_adv_cmd_encoder.sv
// Scoreboard bench for adv_cmd_encoder: stimulus pushes expected pulses (direction and cycle),
// a negedge monitor pops and compares whenever any move output is high.
module tb_adv_cmd_encoder;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       btn_n, btn_s, btn_e, btn_w;
   logic       win, d;
   logic       n, s, e, w;
   logic       busy, locked;
   logic [7:0] cmd_count;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [3:0] dir;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];

   adv_cmd_encoder #(
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn_n    (btn_n),
      .btn_s    (btn_s),
      .btn_e    (btn_e),
      .btn_w    (btn_w),
      .win      (win),
      .d        (d),
      .n        (n),
      .s        (s),
      .e        (e),
      .w        (w),
      .busy     (busy),
      .locked   (locked),
      .cmd_count(cmd_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every visible pulse must match the head of the scoreboard
   always @(negedge clk) begin
      logic [3:0] pulse;
      exp_t       ex;
      pulse = {w, e, s, n};
      if (pulse != 4'b0000) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse got=%b at cyc %0d (none expected)", pulse, cyc);
         end else begin
            ex = exp_q.pop_front();
            if (pulse !== ex.dir || cyc != ex.cyc) begin
               failures++;
               $display("FAIL pulse got=%b@%0d expected=%b@%0d", pulse, cyc, ex.dir, ex.cyc);
            end
         end
      end
   end

   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at cyc %0d", name, act, exp, cyc);
      end
   endtask

   // Pulse appears 7 edges after the edge that first samples the new level
   task automatic expect_pulse(input logic [3:0] dir);
      exp_t ex;
      ex.dir = dir;
      ex.cyc = cyc + 7;
      exp_q.push_back(ex);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      tick(1);
   endtask

   initial begin
      reset_n = 1'b0;
      {btn_n, btn_s, btn_e, btn_w, win, d} = '0;
      tick(2);
      check("rst_moves", {28'd0, w, e, s, n}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_locked", {31'd0, locked}, 32'd0);
      check("rst_count", {24'd0, cmd_count}, 32'd0);
      reset_n = 1'b1;
      tick(2);

      // Clean N press held 20 cycles, busy until one cycle after release debounce
      btn_n = 1'b1;
      expect_pulse(4'b0001);
      tick(6);
      check("t1_busy_pre", {31'd0, busy}, 32'd0);
      tick(1);
      check("t1_busy_pulse", {31'd0, busy}, 32'd1);
      tick(13);
      check("t1_count", {24'd0, cmd_count}, 32'd1);
      btn_n = 1'b0;
      tick(6);
      check("t1_busy_hold", {31'd0, busy}, 32'd1);
      tick(1);
      check("t1_busy_end", {31'd0, busy}, 32'd0);
      tick(3);

      // E bounces with 3-cycle high runs: never accepted
      for (int i = 0; i < 2; i++) begin
         btn_e = 1'b1;
         tick(3);
         btn_e = 1'b0;
         tick(3);
      end
      tick(14);
      check("t2_count", {24'd0, cmd_count}, 32'd1);
      check("t2_busy", {31'd0, busy}, 32'd0);

      // N and E together: N wins, E held through N release gives nothing
      btn_n = 1'b1;
      btn_e = 1'b1;
      expect_pulse(4'b0001);
      tick(20);
      btn_n = 1'b0;
      tick(20);
      check("t3_holdoff", {31'd0, busy}, 32'd1);
      check("t3_count_a", {24'd0, cmd_count}, 32'd2);
      btn_e = 1'b0;
      tick(10);
      check("t3_idle", {31'd0, busy}, 32'd0);
      btn_e = 1'b1;
      expect_pulse(4'b0100);
      tick(15);
      btn_e = 1'b0;
      tick(10);
      check("t3_count_b", {24'd0, cmd_count}, 32'd3);

      // Death in IDLE locks out a later S press
      d = 1'b1;
      tick(1);
      d = 1'b0;
      check("t4_locked_d", {31'd0, locked}, 32'd1);
      btn_s = 1'b1;
      tick(15);
      btn_s = 1'b0;
      tick(10);
      check("t4_count_d", {24'd0, cmd_count}, 32'd3);
      check("t4_still_locked", {31'd0, locked}, 32'd1);
      do_reset();
      check("t4_unlock", {31'd0, locked}, 32'd0);
      check("t4_count_rst", {24'd0, cmd_count}, 32'd0);

      // Win coincident with the W pulse: pulse kept and counted, then locked
      btn_w = 1'b1;
      expect_pulse(4'b1000);
      tick(7);
      win = 1'b1;
      tick(1);
      win = 1'b0;
      check("t5_locked_win", {31'd0, locked}, 32'd1);
      check("t5_count_win", {24'd0, cmd_count}, 32'd1);
      check("t5_busy_win", {31'd0, busy}, 32'd0);
      btn_w = 1'b0;
      tick(10);
      do_reset();

      // 256 separate W presses wrap the counter
      for (int i = 0; i < 256; i++) begin
         btn_w = 1'b1;
         expect_pulse(4'b1000);
         tick(8);
         btn_w = 1'b0;
         tick(9);
         if (i == 127) check("t6_count_mid", {24'd0, cmd_count}, 32'd128);
      end
      check("t6_count_wrap", {24'd0, cmd_count}, 32'd0);

      // One ordinary N press, then reset during the next pulse with N held across release
      btn_n = 1'b1;
      expect_pulse(4'b0001);
      tick(20);
      btn_n = 1'b0;
      tick(10);
      check("t7_count_pre", {24'd0, cmd_count}, 32'd1);
      btn_n = 1'b1;
      expect_pulse(4'b0001);
      tick(7);
      #2;
      reset_n = 1'b0;
      #1;
      check("t7_rst_moves", {28'd0, w, e, s, n}, 32'd0);
      check("t7_rst_busy", {31'd0, busy}, 32'd0);
      check("t7_rst_count", {24'd0, cmd_count}, 32'd0);
      tick(2);
      reset_n = 1'b1;
      expect_pulse(4'b0001);
      tick(20);
      check("t7_count_post", {24'd0, cmd_count}, 32'd1);
      btn_n = 1'b0;
      tick(10);
      check("t7_busy_end", {31'd0, busy}, 32'd0);

      check("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
